idu_pipe: RTL and testbench

Registered, parametrised instruction-decode stage for the pipelined core. Accepts fetched instructions from the IFU over a valid/ready handshake, decodes them into the ALU, jump, RAM and register-write control bundle, and reads both GPR operands. Decoded entries are held in a BUF_DEPTH-entry output queue that feeds the EXU over a second valid/ready handshake. Adds the following behaviour:
- pipeline flush on redirect;
- sticky halt after EBREAK;
- optional illegal-instruction detection.

---
 rtl/idu_pipe_pkg.sv | 78 +++++++
 rtl/idu_pipe_dec.sv | 171 +++++++++++++++++
 rtl/idu_pipe.sv | 167 ++++++++++++++++
 tb/tb_idu_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pipe_pkg.sv
// Shared decode encodings and control bundle for the core.
// Holds idu_ctr_t, field encodings, opcodes and INST_EBREAK.
package core_pkg;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [3:0] ALU_TYPE_X    = 4'd0;
  localparam logic [3:0] ALU_TYPE_ADD  = 4'd0;
  localparam logic [3:0] ALU_TYPE_SUB  = 4'd1;
  localparam logic [3:0] ALU_TYPE_XOR  = 4'd2;
  localparam logic [3:0] ALU_TYPE_OR   = 4'd3;
  localparam logic [3:0] ALU_TYPE_AND  = 4'd4;
  localparam logic [3:0] ALU_TYPE_SLL  = 4'd5;
  localparam logic [3:0] ALU_TYPE_SRL  = 4'd6;
  localparam logic [3:0] ALU_TYPE_SRA  = 4'd7;
  localparam logic [3:0] ALU_TYPE_SLT  = 4'd8;
  localparam logic [3:0] ALU_TYPE_SLTU = 4'd9;
  localparam logic [3:0] ALU_TYPE_EQ   = 4'd10;
  localparam logic [3:0] ALU_TYPE_NE   = 4'd11;
  localparam logic [3:0] ALU_TYPE_GE   = 4'd12;
  localparam logic [3:0] ALU_TYPE_GEU  = 4'd13;

  localparam logic [1:0] ALU_RS1_X    = 2'd0;
  localparam logic [1:0] ALU_RS1_GPR  = 2'd0;
  localparam logic [1:0] ALU_RS1_PC   = 2'd1;
  localparam logic [1:0] ALU_RS1_ZERO = 2'd2;

  localparam logic [1:0] ALU_RS2_X    = 2'd0;
  localparam logic [1:0] ALU_RS2_GPR  = 2'd0;
  localparam logic [1:0] ALU_RS2_IMM  = 2'd1;
  localparam logic [1:0] ALU_RS2_ZERO = 2'd2;

  localparam logic [1:0] JMP_X    = 2'd0;
  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_J    = 2'd1;
  localparam logic [1:0] JMP_R    = 2'd2;
  localparam logic [1:0] JMP_B    = 2'd3;

  localparam logic [2:0] RAM_BYT_X  = 3'd0;
  localparam logic [2:0] RAM_BYT_B  = 3'd0;
  localparam logic [2:0] RAM_BYT_H  = 3'd1;
  localparam logic [2:0] RAM_BYT_W  = 3'd2;
  localparam logic [2:0] RAM_BYT_BU = 3'd3;
  localparam logic [2:0] RAM_BYT_HU = 3'd4;

  localparam logic [1:0] REG_WR_SRC_X    = 2'd0;
  localparam logic [1:0] REG_WR_SRC_ALU  = 2'd0;
  localparam logic [1:0] REG_WR_SRC_RAM  = 2'd1;
  localparam logic [1:0] REG_WR_SRC_SNPC = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu_type;
    logic [1:0] alu_rs1;
    logic [1:0] alu_rs2;
    logic [1:0] jmp_type;
    logic       ram_wr_en;
    logic [2:0] ram_byt;
    logic       reg_wr_en;
    logic [1:0] reg_wr_src;
  } idu_ctr_t;

endpackage

// File: rtl/idu_pipe_dec.sv
// idu_imm: sign-extended immediate of a format; idu_dec: inst -> ctr/imm.
// Optional illegal output exists only with IDU_ILLEGAL_TRAP_EN.
module idu_imm
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  input  imm_fmt_e              fmt,
  output logic [DATA_WIDTH-1:0] imm
);
  logic signed [31:0] imm_s;

  always_comb begin
    imm_s = '0;
    unique case (fmt)
      IMM_I: imm_s = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm_s = {{19{inst[31]}}, inst[31], inst[7],
                      inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm_s = {inst[31:12], 12'b0};
      IMM_J: imm_s = {{11{inst[31]}}, inst[31], inst[19:12],
                      inst[20], inst[30:21], 1'b0};
      default: imm_s = '0;
    endcase
  end

  assign imm = DATA_WIDTH'(imm_s);
endmodule

module idu_dec
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  output idu_ctr_t              ctr,
  output logic [DATA_WIDTH-1:0] imm
`ifdef IDU_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_e   fmt;
  idu_ctr_t   c;
  logic       bad;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    c   = '0;
    fmt = IMM_NONE;
    bad = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        c.alu_rs1   = ALU_RS1_ZERO;
        c.alu_rs2   = ALU_RS2_IMM;
        c.reg_wr_en = 1'b1;
        fmt         = IMM_U;
      end
      opc == OPC_AUIPC: begin
        c.alu_rs1   = ALU_RS1_PC;
        c.alu_rs2   = ALU_RS2_IMM;
        c.reg_wr_en = 1'b1;
        fmt         = IMM_U;
      end
      opc == OPC_JAL: begin
        c.alu_rs1    = ALU_RS1_PC;
        c.alu_rs2    = ALU_RS2_IMM;
        c.jmp_type   = JMP_J;
        c.reg_wr_en  = 1'b1;
        c.reg_wr_src = REG_WR_SRC_SNPC;
        fmt          = IMM_J;
      end
      opc == OPC_JALR: begin
        c.alu_rs2    = ALU_RS2_IMM;
        c.jmp_type   = JMP_R;
        c.reg_wr_en  = 1'b1;
        c.reg_wr_src = REG_WR_SRC_SNPC;
        fmt          = IMM_I;
      end
      opc == OPC_BRANCH: begin
        c.jmp_type = JMP_B;
        fmt        = IMM_B;
        case (f3)
          3'b000:  c.alu_type = ALU_TYPE_EQ;
          3'b001:  c.alu_type = ALU_TYPE_NE;
          3'b100:  c.alu_type = ALU_TYPE_SLT;
          3'b101:  c.alu_type = ALU_TYPE_GE;
          3'b110:  c.alu_type = ALU_TYPE_SLTU;
          3'b111:  c.alu_type = ALU_TYPE_GEU;
          default: bad = 1'b1;
        endcase
      end
      opc == OPC_LOAD: begin
        c.alu_rs2    = ALU_RS2_IMM;
        c.reg_wr_en  = 1'b1;
        c.reg_wr_src = REG_WR_SRC_RAM;
        fmt          = IMM_I;
        case (f3)
          3'b000:  c.ram_byt = RAM_BYT_B;
          3'b001:  c.ram_byt = RAM_BYT_H;
          3'b010:  c.ram_byt = RAM_BYT_W;
          3'b100:  c.ram_byt = RAM_BYT_BU;
          3'b101:  c.ram_byt = RAM_BYT_HU;
          default: bad = 1'b1;
        endcase
      end
      opc == OPC_STORE: begin
        c.alu_rs2   = ALU_RS2_IMM;
        c.ram_wr_en = 1'b1;
        fmt         = IMM_S;
        case (f3)
          3'b000:  c.ram_byt = RAM_BYT_B;
          3'b001:  c.ram_byt = RAM_BYT_H;
          3'b010:  c.ram_byt = RAM_BYT_W;
          default: bad = 1'b1;
        endcase
      end
      opc == OPC_OP_IMM || opc == OPC_OP: begin
        c.reg_wr_en = 1'b1;
        if (opc == OPC_OP_IMM) begin
          c.alu_rs2 = ALU_RS2_IMM;
          fmt       = IMM_I;
        end
        case (f3)
          3'b000: c.alu_type = (opc == OPC_OP && f7[5])
                             ? ALU_TYPE_SUB : ALU_TYPE_ADD;
          3'b001: c.alu_type = ALU_TYPE_SLL;
          3'b010: c.alu_type = ALU_TYPE_SLT;
          3'b011: c.alu_type = ALU_TYPE_SLTU;
          3'b100: c.alu_type = ALU_TYPE_XOR;
          3'b101: c.alu_type = inst[30]
                             ? ALU_TYPE_SRA : ALU_TYPE_SRL;
          3'b110: c.alu_type = ALU_TYPE_OR;
          default: c.alu_type = ALU_TYPE_AND;
        endcase
        if (opc == OPC_OP) begin
          if (f7 != 7'h00 && f7 != 7'h20)
            bad = 1'b1;
          if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101)
            bad = 1'b1;
        end
      end
      opc == OPC_FENCE || opc == OPC_SYSTEM: begin
        c = '0;
      end
      default: bad = 1'b1;
    endcase
    // Anything malformed degrades to the no-op bundle.
    if (bad)
      c = '0;
  end

  assign ctr = c;

`ifdef IDU_ILLEGAL_TRAP_EN
  assign illegal = bad;
`endif

  idu_imm #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
    .inst (inst),
    .fmt  (fmt),
    .imm  (imm)
  );
endmodule

// File: rtl/idu_pipe.sv
// Decode stage: decodes IFU instructions into a BUF_DEPTH output queue.
// Ports: IFU/EXU valid-ready, GPR read, flush, halt; IDU_ILLEGAL_TRAP_EN.
module idu_pipe
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic                    i_sys_flush,
  input  logic                    i_ifu_valid,
  output logic                    o_idu_ready,
  input  logic [31:0]             i_ifu_inst,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_pc,
  output logic [4:0]              o_idu_gpr_rs1_id,
  output logic [4:0]              o_idu_gpr_rs2_id,
  input  logic [DATA_WIDTH-1:0]   i_gpr_rs1_data,
  input  logic [DATA_WIDTH-1:0]   i_gpr_rs2_data,
  output logic                    o_idu_valid,
  input  logic                    i_exu_ready,
  output logic [ADDR_WIDTH-1:0]   o_idu_pc,
  output idu_ctr_t                o_idu_ctr,
  output logic [4:0]              o_idu_gpr_rd_id,
  output logic [DATA_WIDTH-1:0]   o_idu_rs1_data,
  output logic [DATA_WIDTH-1:0]   o_idu_rs2_data,
  output logic [DATA_WIDTH-1:0]   o_idu_jmp_or_reg_data,
  output logic                    o_idu_end_flag,
  output logic                    o_idu_halt,
`ifdef IDU_ILLEGAL_TRAP_EN
  output logic                    o_idu_illegal,
`endif
  output logic [$clog2(BUF_DEPTH):0] o_idu_cnt
);
  localparam int PW = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    idu_ctr_t              ctr;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] jr;
    logic                  end_flag;
`ifdef IDU_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
  } ent_t;

  ent_t                  q [BUF_DEPTH];
  ent_t                  ent_in;
  ent_t                  hd;
  idu_ctr_t              dec_ctr;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           cnt;
  logic                  halt;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  halt_set;

`ifdef IDU_ILLEGAL_TRAP_EN
  logic dec_ill;

  idu_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst    (i_ifu_inst),
    .ctr     (dec_ctr),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );
`else
  idu_dec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .inst (i_ifu_inst),
    .ctr  (dec_ctr),
    .imm  (dec_imm)
  );
`endif

  assign o_idu_gpr_rs1_id = i_ifu_inst[19:15];
  assign o_idu_gpr_rs2_id = i_ifu_inst[24:20];

  always_comb begin
    ent_in          = '0;
    ent_in.pc       = i_ifu_pc;
    ent_in.ctr      = dec_ctr;
    ent_in.rd       = i_ifu_inst[11:7];
    ent_in.end_flag = (i_ifu_inst == INST_EBREAK);
    unique case (dec_ctr.alu_rs1)
      ALU_RS1_GPR: ent_in.rs1 = i_gpr_rs1_data;
      ALU_RS1_PC:  ent_in.rs1 = DATA_WIDTH'(i_ifu_pc);
      default:     ent_in.rs1 = '0;
    endcase
    unique case (dec_ctr.alu_rs2)
      ALU_RS2_GPR: ent_in.rs2 = i_gpr_rs2_data;
      ALU_RS2_IMM: ent_in.rs2 = dec_imm;
      default:     ent_in.rs2 = '0;
    endcase
    ent_in.jr = (dec_ctr.jmp_type == JMP_B)
              ? dec_imm : i_gpr_rs2_data;
`ifdef IDU_ILLEGAL_TRAP_EN
    ent_in.illegal = dec_ill;
`endif
  end

`ifdef IDU_ILLEGAL_TRAP_EN
  assign halt_set = ent_in.end_flag | dec_ill;
`else
  assign halt_set = ent_in.end_flag;
`endif

  // Ready depends on registered state only.
  assign full        = (cnt == (PW+1)'(BUF_DEPTH));
  assign o_idu_ready = !full && !halt;
  assign o_idu_valid = (cnt != '0);
  assign push = i_ifu_valid && o_idu_ready && !i_sys_flush;
  assign pop  = o_idu_valid && i_exu_ready && !i_sys_flush;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      halt <= 1'b0;
    end else begin
      if (i_sys_flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push)
          tail <= tail + 1'b1;
        if (pop)
          head <= head + 1'b1;
        if (push && !pop)
          cnt <= cnt + 1'b1;
        else if (pop && !push)
          cnt <= cnt - 1'b1;
      end
      if (push && halt_set)
        halt <= 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (push && !i_sys_rst)
      q[tail] <= ent_in;
  end

  // Head fields read as zero while the queue is empty.
  assign hd = o_idu_valid ? q[head] : '0;

  assign o_idu_pc              = hd.pc;
  assign o_idu_ctr             = hd.ctr;
  assign o_idu_gpr_rd_id       = hd.rd;
  assign o_idu_rs1_data        = hd.rs1;
  assign o_idu_rs2_data        = hd.rs2;
  assign o_idu_jmp_or_reg_data = hd.jr;
  assign o_idu_end_flag        = hd.end_flag;
  assign o_idu_halt            = halt;
  assign o_idu_cnt             = cnt;
`ifdef IDU_ILLEGAL_TRAP_EN
  assign o_idu_illegal         = hd.illegal;
`endif
endmodule

// File: tb/tb_idu_pipe.sv
// Scoreboard bench for idu_pipe: directed decode, stall, flush, halt.
// Honours IDU_ILLEGAL_TRAP_EN for the illegal-instruction case.
module tb_idu_pipe;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ifu_valid = 1'b0;
  logic        idu_ready;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_d = '0, rs2_d = '0;
  logic        idu_valid;
  logic        exu_ready = 1'b1;
  logic [31:0] o_pc;
  idu_ctr_t    o_ctr;
  logic [4:0]  o_rd;
  logic [31:0] o_rs1, o_rs2, o_jr;
  logic        o_end, o_halt;
  logic        o_ill;
  logic [1:0]  o_cnt;

  idu_pipe dut (
    .i_sys_clk             (clk),
    .i_sys_rst             (rst),
    .i_sys_flush           (flush),
    .i_ifu_valid           (ifu_valid),
    .o_idu_ready           (idu_ready),
    .i_ifu_inst            (inst),
    .i_ifu_pc              (pc),
    .o_idu_gpr_rs1_id      (rs1_id),
    .o_idu_gpr_rs2_id      (rs2_id),
    .i_gpr_rs1_data        (rs1_d),
    .i_gpr_rs2_data        (rs2_d),
    .o_idu_valid           (idu_valid),
    .i_exu_ready           (exu_ready),
    .o_idu_pc              (o_pc),
    .o_idu_ctr             (o_ctr),
    .o_idu_gpr_rd_id       (o_rd),
    .o_idu_rs1_data        (o_rs1),
    .o_idu_rs2_data        (o_rs2),
    .o_idu_jmp_or_reg_data (o_jr),
    .o_idu_end_flag        (o_end),
    .o_idu_halt            (o_halt),
`ifdef IDU_ILLEGAL_TRAP_EN
    .o_idu_illegal         (o_ill),
`endif
    .o_idu_cnt             (o_cnt)
  );

`ifndef IDU_ILLEGAL_TRAP_EN
  assign o_ill = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    idu_ctr_t    ctr;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] jr;
    logic        end_flag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic idu_ctr_t mkc(
    input logic [3:0] at, input logic [1:0] r1,
    input logic [1:0] r2, input logic [1:0] jt,
    input logic rw, input logic [2:0] by,
    input logic we, input logic [1:0] src);
    idu_ctr_t c;
    c.alu_type = at;  c.alu_rs1 = r1;
    c.alu_rs2 = r2;   c.jmp_type = jt;
    c.ram_wr_en = rw; c.ram_byt = by;
    c.reg_wr_en = we; c.reg_wr_src = src;
    return c;
  endfunction

  function automatic exp_t mke(
    input logic [31:0] p, input idu_ctr_t c, input logic [4:0] rd,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] j, input logic e, input logic il);
    exp_t x;
    x.pc = p; x.ctr = c; x.rd = rd; x.rs1 = a;
    x.rs2 = b; x.jr = j; x.end_flag = e; x.ill = il;
    return x;
  endfunction

  // Monitor: pops one expectation per consumed head entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && idu_valid && exu_ready && !flush) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got pc %0h expected none",
                   o_pc);
        end else begin
          e = sb.pop_front();
          chk("pc",  64'(o_pc),  64'(e.pc));
          chk("ctr", 64'(o_ctr), 64'(e.ctr));
          chk("rd",  64'(o_rd),  64'(e.rd));
          chk("rs1", 64'(o_rs1), 64'(e.rs1));
          chk("rs2", 64'(o_rs2), 64'(e.rs2));
          chk("jr",  64'(o_jr),  64'(e.jr));
          chk("end", 64'(o_end), 64'(e.end_flag));
`ifdef IDU_ILLEGAL_TRAP_EN
          chk("ill", 64'(o_ill), 64'(e.ill));
`endif
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    inst = i; pc = p; rs1_d = a; rs2_d = b; ifu_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input exp_t e);
    bit ok = 0;
    drive(i, p, a, b);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (idu_ready && !flush) begin
        sb.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    ifu_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      if (o_cnt == 0 && sb.size() == 0) ok = 1;
    end
    chk("drain", 64'(ok), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_SUB  = 32'h4020_81b3;
  localparam logic [31:0] I_BEQ  = 32'hfe20_8ce3;
  localparam logic [31:0] I_LUI  = 32'h1234_52b7;
  localparam logic [31:0] I_SW   = 32'h0020_a623;
  localparam logic [31:0] I_AUI  = 32'h0000_1397;
  localparam logic [31:0] I_JAL  = 32'h0100_00ef;
  localparam logic [31:0] I_LW   = 32'hffc1_2203;
  localparam logic [31:0] I_BAD  = 32'hffff_ffff;

  idu_ctr_t c_addi, c_sub, c_beq, c_lui, c_sw, c_aui, c_jal, c_lw;
  idu_ctr_t c_nop;
  exp_t     e_addi;

  initial begin
    c_addi = mkc(ALU_TYPE_ADD, ALU_RS1_GPR, ALU_RS2_IMM, JMP_NONE,
                 0, RAM_BYT_B, 1, REG_WR_SRC_ALU);
    c_sub  = mkc(ALU_TYPE_SUB, ALU_RS1_GPR, ALU_RS2_GPR, JMP_NONE,
                 0, RAM_BYT_B, 1, REG_WR_SRC_ALU);
    c_beq  = mkc(ALU_TYPE_EQ, ALU_RS1_GPR, ALU_RS2_GPR, JMP_B,
                 0, RAM_BYT_B, 0, REG_WR_SRC_ALU);
    c_lui  = mkc(ALU_TYPE_ADD, ALU_RS1_ZERO, ALU_RS2_IMM, JMP_NONE,
                 0, RAM_BYT_B, 1, REG_WR_SRC_ALU);
    c_sw   = mkc(ALU_TYPE_ADD, ALU_RS1_GPR, ALU_RS2_IMM, JMP_NONE,
                 1, RAM_BYT_W, 0, REG_WR_SRC_ALU);
    c_aui  = mkc(ALU_TYPE_ADD, ALU_RS1_PC, ALU_RS2_IMM, JMP_NONE,
                 0, RAM_BYT_B, 1, REG_WR_SRC_ALU);
    c_jal  = mkc(ALU_TYPE_ADD, ALU_RS1_PC, ALU_RS2_IMM, JMP_J,
                 0, RAM_BYT_B, 1, REG_WR_SRC_SNPC);
    c_lw   = mkc(ALU_TYPE_ADD, ALU_RS1_GPR, ALU_RS2_IMM, JMP_NONE,
                 0, RAM_BYT_W, 1, REG_WR_SRC_RAM);
    c_nop  = '0;
    e_addi = mke(32'h100, c_addi, 1, 0, 5, 32'h77, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt",   64'(o_cnt),     64'(0));
    chk("rst_valid", 64'(idu_valid), 64'(0));
    chk("rst_halt",  64'(o_halt),    64'(0));
    chk("rst_ready", 64'(idu_ready), 64'(1));
    chk("rst_rs1",   64'(o_rs1),     64'(0));
    @(posedge clk); #1;

    // Back-to-back stream, EXU always ready.
    send(I_ADDI, 32'h100, 0, 32'h77, e_addi);
    @(negedge clk);
    chk("lat_valid", 64'(idu_valid), 64'(1));
    @(posedge clk); #1;
    send(I_SUB, 32'h104, 10, 3,
         mke(32'h104, c_sub, 3, 10, 3, 3, 0, 0));
    send(I_BEQ, 32'h108, 7, 9,
         mke(32'h108, c_beq, 25, 7, 9, 32'hffff_fff8, 0, 0));
    send(I_LUI, 32'h10c, 1, 2,
         mke(32'h10c, c_lui, 5, 0, 32'h1234_5000, 2, 0, 0));
    send(I_SW, 32'h110, 32'h40, 32'hdead,
         mke(32'h110, c_sw, 12, 32'h40, 12, 32'hdead, 0, 0));
    send(I_AUI, 32'h200, 4, 5,
         mke(32'h200, c_aui, 7, 32'h200, 32'h1000, 5, 0, 0));
    send(I_JAL, 32'h300, 4, 6,
         mke(32'h300, c_jal, 1, 32'h300, 16, 6, 0, 0));
    send(I_LW, 32'h304, 32'h80, 1,
         mke(32'h304, c_lw, 4, 32'h80, 32'hffff_fffc, 1, 0, 0));
    drain();

    // Stall: third push held off until a slot frees.
    exu_ready = 1'b0;
    send(I_ADDI, 32'h400, 0, 32'h77,
         mke(32'h400, c_addi, 1, 0, 5, 32'h77, 0, 0));
    send(I_SUB, 32'h404, 10, 3,
         mke(32'h404, c_sub, 3, 10, 3, 3, 0, 0));
    drive(I_SUB, 32'h408, 20, 6);
    @(negedge clk);
    chk("full_cnt",   64'(o_cnt),     64'(2));
    chk("full_ready", 64'(idu_ready), 64'(0));
    @(posedge clk); #1 exu_ready = 1'b1;
    @(negedge clk);
    chk("still_full", 64'(o_cnt), 64'(2));
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_pop_cnt",   64'(o_cnt),     64'(1));
    chk("after_pop_ready", 64'(idu_ready), 64'(1));
    sb.push_back(mke(32'h408, c_sub, 3, 20, 6, 6, 0, 0));
    @(posedge clk); #1 ifu_valid = 1'b0;
    @(negedge clk);
    chk("pushpop_cnt", 64'(o_cnt), 64'(1));
    drain();

    // Flush with a full queue and a push/pop offered.
    exu_ready = 1'b0;
    send(I_ADDI, 32'h500, 0, 0,
         mke(32'h500, c_addi, 1, 0, 5, 0, 0, 0));
    send(I_ADDI, 32'h504, 0, 0,
         mke(32'h504, c_addi, 1, 0, 5, 0, 0, 0));
    drive(I_ADDI, 32'h508, 0, 0);
    exu_ready = 1'b1;
    flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    ifu_valid = 1'b0;
    @(negedge clk);
    chk("flush_cnt",   64'(o_cnt),     64'(0));
    chk("flush_valid", 64'(idu_valid), 64'(0));
    chk("flush_ready", 64'(idu_ready), 64'(1));
    @(posedge clk); #1;

    // EBREAK then ADDI: halt sticks, ADDI refused.
    send(INST_EBREAK, 32'h600, 0, 0,
         mke(32'h600, c_nop, 0, 0, 0, 0, 1, 0));
    drive(I_ADDI, 32'h604, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt",       64'(o_halt),    64'(1));
      chk("halt_ready", 64'(idu_ready), 64'(0));
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("halt_flush", 64'(o_halt), 64'(1));
    chk("halt_cnt",   64'(o_cnt),  64'(0));
    ifu_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_unhalt", 64'(o_halt),    64'(0));
    chk("rst_ready2", 64'(idu_ready), 64'(1));
    @(posedge clk); #1;

    // All-ones word: unknown opcode.
`ifdef IDU_ILLEGAL_TRAP_EN
    send(I_BAD, 32'h700, 32'h11, 32'h22,
         mke(32'h700, c_nop, 31, 32'h11, 32'h22, 32'h22, 0, 1));
    drain();
    chk("ill_halt", 64'(o_halt), 64'(1));
`else
    send(I_BAD, 32'h700, 32'h11, 32'h22,
         mke(32'h700, c_nop, 31, 32'h11, 32'h22, 32'h22, 0, 0));
    drain();
    chk("ill_halt", 64'(o_halt), 64'(0));
`endif
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
